// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings and decode types for the multi-cycle controller
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_IEXEC  = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    typedef enum logic [2:0] {
        CLS_LOAD, CLS_STORE, CLS_RTYPE, CLS_IALU, CLS_BRANCH, CLS_JUMP, CLS_ILLEGAL
    } op_class_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    localparam logic [1:0] SRCB_REG    = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_FUNCT = 3'd2;
    localparam logic [2:0] ALU_AND   = 3'd3;
    localparam logic [2:0] ALU_OR    = 3'd4;
    localparam logic [2:0] ALU_XOR   = 3'd5;
    localparam logic [2:0] ALU_SLT   = 3'd6;
    localparam logic [2:0] ALU_SLTU  = 3'd7;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_REG    = 2'd3;

    // Everything the later states need to know about the instruction,
    // captured once in DECODE so IR changes afterwards cannot disturb it.
    typedef struct packed {
        op_class_t  cls;
        logic       ext_op;
        logic       lui_op;
        logic [2:0] alu_op;
        logic       link;
        logic       jump_reg;
    } decode_t;

    function automatic logic is_wait_state(state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode/funct classification
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output decode_t    dec_o
);

    // Map OpCode/Funct to an instruction class plus the per-op extender/ALU controls
    always_comb begin
        dec_o.cls      = CLS_ILLEGAL;
        dec_o.ext_op   = 1'b1;
        dec_o.lui_op   = 1'b0;
        dec_o.alu_op   = ALU_ADD;
        dec_o.link     = 1'b0;
        dec_o.jump_reg = 1'b0;
        case (op_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_JR: begin
                        dec_o.cls      = CLS_JUMP;
                        dec_o.jump_reg = 1'b1;
                    end
                    FN_JALR: begin
                        dec_o.cls      = CLS_JUMP;
                        dec_o.jump_reg = 1'b1;
                        dec_o.link     = 1'b1;
                    end
                    FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                    FN_SLT, FN_SLTU: begin
                        dec_o.cls    = CLS_RTYPE;
                        dec_o.alu_op = ALU_FUNCT;
                    end
                    default: begin
                        // add/addu/sub/subu/and/or/xor/nor occupy 0x20..0x27
                        if (funct_i >= FN_ADD && funct_i <= FN_NOR) begin
                            dec_o.cls    = CLS_RTYPE;
                            dec_o.alu_op = ALU_FUNCT;
                        end
                    end
                endcase
            end
            OP_J:             dec_o.cls = CLS_JUMP;
            OP_JAL: begin
                dec_o.cls  = CLS_JUMP;
                dec_o.link = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec_o.cls    = CLS_BRANCH;
                dec_o.alu_op = ALU_SUB;
            end
            OP_ADDI, OP_ADDIU: dec_o.cls = CLS_IALU;
            OP_SLTI: begin
                dec_o.cls    = CLS_IALU;
                dec_o.alu_op = ALU_SLT;
            end
            OP_SLTIU: begin
                dec_o.cls    = CLS_IALU;
                dec_o.alu_op = ALU_SLTU;
            end
            OP_ANDI: begin
                dec_o.cls    = CLS_IALU;
                dec_o.ext_op = 1'b0;
                dec_o.alu_op = ALU_AND;
            end
            OP_ORI: begin
                dec_o.cls    = CLS_IALU;
                dec_o.ext_op = 1'b0;
                dec_o.alu_op = ALU_OR;
            end
            OP_XORI: begin
                dec_o.cls    = CLS_IALU;
                dec_o.ext_op = 1'b0;
                dec_o.alu_op = ALU_XOR;
            end
            OP_LUI: begin
                dec_o.cls    = CLS_IALU;
                dec_o.lui_op = 1'b1;
            end
            OP_LW:   dec_o.cls = CLS_LOAD;
            OP_SW:   dec_o.cls = CLS_STORE;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS-subset main controller FSM
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter bit          MEM_WAIT_EN    = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OpCode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       ExtOp,
    output logic       LuiOp,
    output logic       instr_done,
    output logic       illegal_instr,
    output logic       mem_timeout,
    output logic [3:0] state
);

    state_t      state_q, state_d;
    decode_t     dec_now, dec_q, dec_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        timeout_q, timeout_d;
    logic        ready;
    logic        unused_zero;

    // The branch condition is resolved in the datapath from PCWriteCond and Zero.
    assign unused_zero = Zero;
    assign ready       = MEM_WAIT_EN ? mem_ready : 1'b1;
    assign state       = state_q;
    assign mem_timeout = timeout_q;

    ctrl_decode u_decode (
        .op_i    (OpCode),
        .funct_i (Funct),
        .dec_o   (dec_now)
    );

    // State register, latched decode, wait counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            dec_q      <= '0;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dec_q      <= dec_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Wait counting: a wait state is only ever left on a ready cycle, so
    // clearing on ready also covers the clear-on-state-change case.
    always_comb begin
        wait_cnt_d = '0;
        if (is_wait_state(state_q) && !ready) begin
            wait_cnt_d = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : wait_cnt_q + 16'd1;
        end
        timeout_d = timeout_q;
        if (TIMEOUT_CYCLES != 0 && {16'd0, wait_cnt_q} == TIMEOUT_CYCLES) begin
            timeout_d = 1'b1;
        end
    end

    // Next-state and datapath controls from the current state and latched decode
    always_comb begin
        state_d       = state_q;
        dec_d         = dec_q;
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        RegDst        = REGDST_RT;
        MemtoReg      = M2R_ALUOUT;
        ALUSrcA       = 1'b0;
        ALUSrcB       = SRCB_REG;
        ALUOp         = ALU_ADD;
        PCSource      = PCSRC_ALU;
        ExtOp         = 1'b1;
        LuiOp         = 1'b0;
        instr_done    = 1'b0;
        illegal_instr = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = ready;
                PCWrite = ready;
                if (ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM_SH;
                dec_d   = dec_now;
                case (dec_now.cls)
                    CLS_LOAD, CLS_STORE: state_d = S_MEMADR;
                    CLS_RTYPE:           state_d = S_REXEC;
                    CLS_IALU:            state_d = S_IEXEC;
                    CLS_BRANCH:          state_d = S_BRANCH;
                    CLS_JUMP:            state_d = S_JUMP;
                    default: begin
                        illegal_instr = 1'b1;
                        instr_done    = 1'b1;
                        state_d       = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = (dec_q.cls == CLS_STORE) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                if (ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = M2R_MDR;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                IorD       = 1'b1;
                MemWrite   = ready;
                instr_done = ready;
                if (ready) state_d = S_FETCH;
            end
            S_REXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_FUNCT;
                state_d = S_RWB;
            end
            S_RWB: begin
                RegWrite   = 1'b1;
                RegDst     = REGDST_RD;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ExtOp   = dec_q.ext_op;
                LuiOp   = dec_q.lui_op;
                ALUOp   = dec_q.alu_op;
                state_d = S_IWB;
            end
            S_IWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                instr_done  = 1'b1;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = dec_q.jump_reg ? PCSRC_REG : PCSRC_JUMP;
                RegWrite   = dec_q.link;
                RegDst     = dec_q.jump_reg ? REGDST_RD : REGDST_RA;
                MemtoReg   = M2R_PC;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        // A reset cycle must never commit anything, even mid-instruction.
        if (reset) begin
            PCWrite       = 1'b0;
            PCWriteCond   = 1'b0;
            MemRead       = 1'b0;
            MemWrite      = 1'b0;
            IRWrite       = 1'b0;
            RegWrite      = 1'b0;
            instr_done    = 1'b0;
            illegal_instr = 1'b0;
        end
    end

endmodule
